// File: rtl/cmp1_checker.sv
`default_nettype none
// ============================================================================
// cmp1_checker -- sweeps all {a,b} pairs into a 1-bit comparator and counts
//                 result mismatches over ROUNDS sweeps.
// Revision: 1.0
// ============================================================================
module cmp1_checker #(
   parameter int SETTLE = 1,
   parameter int ROUNDS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       eq,
   input  logic       neq,
   input  logic       big,
   input  logic       sma,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_cnt,
   output logic [1:0] first_fail
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRIVE = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [3:0] SETTLE_C   = 4'(SETTLE);
   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] round_q, round_d;
   logic [3:0] cnt_q, cnt_d;
   logic       a_q, a_d, b_q, b_d;
   logic [3:0] err_q, err_d;
   logic [1:0] ff_q, ff_d;

   logic [3:0] got, want;
   logic       mismatch;

   assign got      = {eq, neq, big, sma};
   assign want     = {a_q == b_q, a_q != b_q, a_q & ~b_q, ~a_q & b_q};
   assign mismatch = (got != want);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         round_q <= 4'd0;
         cnt_q   <= 4'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         err_q   <= 4'd0;
         ff_q    <= 2'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         round_q <= round_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      round_d = round_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      err_d   = err_q;
      ff_d    = ff_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_DRIVE;
               idx_d   = 2'd0;
               round_d = 4'd0;
               cnt_d   = 4'd0;
               err_d   = 4'd0;
               ff_d    = 2'd0;
            end
         end
         S_DRIVE: begin
            a_d = idx_q[1];
            b_d = idx_q[0];
            if (SETTLE == 0) begin
               state_d = S_CHECK;
            end else begin
               state_d = S_WAIT;
               cnt_d   = SETTLE_C;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (mismatch) begin
               if (err_q != 4'd15) begin
                  err_d = err_q + 4'd1;
               end
               if (err_q == 4'd0) begin
                  ff_d = {a_q, b_q};
               end
            end
            if (idx_q == 2'd3 && round_q == LAST_ROUND) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRIVE;
               idx_d   = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  round_d = round_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign a          = a_q;
   assign b          = b_q;
   assign busy       = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
   assign done       = (state_q == S_DONE);
   assign pass       = (state_q == S_DONE) && (err_q == 4'd0);
   assign err_cnt    = err_q;
   assign first_fail = ff_q;

endmodule
`default_nettype wire
